// File: rtl/fetch_pkg.sv
// Fetch stage shared package.
// Constants, FSM encoding and IF/ID bundle types.
package fetch_pkg;

  localparam logic [15:0] IF_NOP    = 16'h0800;
  localparam logic [15:0] IF_PC_INC = 16'd2;
  localparam logic [4:0]  OP_HALT   = 5'b00000;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  typedef struct packed {
    logic [15:0] instr;
    logic        err;
  } hold_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] next_pc;
    logic        err;
  } if_id_t;

  function automatic logic stops_fetch(
    input logic [15:0] instr,
    input logic        err
  );
    return err || (instr[15:11] == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid buffer (instr + err).
// Load captures d, clear empties it; clear wins.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [16:0] d,
  output logic [16:0] q
);

  // Capture or clear the parked response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem requests,
// IF/ID register, stall/redirect/halt handling.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = IF_NOP,
  parameter logic [15:0] PC_INC    = IF_PC_INC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  input  logic        haltIn,
  output logic        imemReq,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemRdata,
  input  logic        imemDone,
  input  logic        imemErr,
  output logic [15:0] instrOut,
  output logic [15:0] nextPcOut,
  output logic        errOut,
  output logic        halted
);

  logic [1:0]  state;
  logic [1:0]  state_d;
  logic        squash;
  logic        squash_d;
  logic [15:0] pc;
  logic [15:0] pc_d;
  logic [15:0] pc_inc;
  if_id_t      ifid;
  if_id_t      ifid_d;
  if_id_t      bubble;
  logic        hb_load;
  logic        hb_clear;
  logic [16:0] hb_q;
  hold_t       hb;

  assign bubble = '{instr: NOP_INSTR, next_pc: 16'h0, err: 1'b0};
  assign hb     = hb_q;
  assign pc_inc = pc + PC_INC;

  fetch_hold_buf u_hold (
    .clk   (clk),
    .rst_n (rst),
    .load  (hb_load),
    .clear (hb_clear),
    .d     ({imemRdata, imemErr}),
    .q     (hb_q)
  );

  // Next-state: halt > redirect > response/stall handling
  always_comb begin
    state_d  = state;
    squash_d = squash;
    pc_d     = pc;
    ifid_d   = ifid;
    hb_load  = 1'b0;
    hb_clear = 1'b0;
    if (haltIn) begin
      state_d  = ST_HALTED;
      ifid_d   = bubble;
      hb_clear = 1'b1;
    end else if (state == ST_HALTED) begin
      state_d = ST_HALTED;
    end else if (redirect) begin
      state_d  = ST_FETCH;
      pc_d     = redirectPc;
      ifid_d   = bubble;
      hb_clear = 1'b1;
      squash_d = (state == ST_FETCH) && !imemDone;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (imemDone) begin
            if (squash) begin
              squash_d = 1'b0;
            end else if (stall) begin
              hb_load = 1'b1;
              state_d = ST_HOLD;
            end else begin
              ifid_d = '{instr: imemRdata,
                         next_pc: pc_inc,
                         err: imemErr};
              pc_d   = pc_inc;
              if (stops_fetch(imemRdata, imemErr))
                state_d = ST_DRAIN;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_d   = '{instr: hb.instr,
                         next_pc: pc_inc,
                         err: hb.err};
            pc_d     = pc_inc;
            hb_clear = 1'b1;
            state_d  = stops_fetch(hb.instr, hb.err)
                       ? ST_DRAIN : ST_FETCH;
          end
        end
        ST_DRAIN: state_d = ST_DRAIN;
        default:  state_d = state;
      endcase
    end
  end

  // Control state and PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_FETCH;
      squash <= 1'b0;
      pc     <= RESET_PC;
    end else begin
      state  <= state_d;
      squash <= squash_d;
      pc     <= pc_d;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid <= '{instr: NOP_INSTR, next_pc: 16'h0, err: 1'b0};
    end else begin
      ifid <= ifid_d;
    end
  end

  assign imemReq   = (state == ST_FETCH) && !squash;
  assign imemAddr  = pc;
  assign instrOut  = ifid.instr;
  assign nextPcOut = ifid.next_pc;
  assign errOut    = ifid.err;
  assign halted    = (state == ST_HALTED);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage 16-bit pipeline, the producer side of the decode stage's instrIn/nextPcIn interface.
- Holds the PC and issues requests to a variable-latency instruction memory.
- Owns the IF/ID pipeline register: drives instrOut, nextPcOut and errOut into decode.
- Honours stall from hazard detection, redirect from branch/jump resolution, and halt retirement.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, bubble instruction (opcode 00001) driven on flush/reset.
PC_INC, 2, byte increment per sequential instruction.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  decode cannot accept; hold IF/ID register
redirect  in  1  taken branch/jump/return; flush and refetch
redirectPc  in  16  target PC, valid with redirect
haltIn  in  1  HALT retired downstream; stop permanently
imemReq  out  1  instruction memory request
imemAddr  out  16  request address (= PC)
imemRdata  in  16  fetched instruction, valid with imemDone
imemDone  in  1  response valid; may be same cycle as request
imemErr  in  1  response error, valid with imemDone
instrOut  out  16  IF/ID instruction to decode
nextPcOut  out  16  IF/ID PC+2 to decode
errOut  out  1  IF/ID fetch error, travels with instruction
halted  out  1  fetch permanently stopped

Behaviour:
- Reset (rst low, async): pc=RESET_PC, state=FETCH, squash=0, instrOut=NOP_INSTR, nextPcOut=0, errOut=0, halted=0, hold buffer cleared.
- FSM states: FETCH, HOLD, DRAIN, HALTED.
- Outputs: imemReq = (state==FETCH); imemAddr = pc. pc is stable while imemReq is high. A request is outstanding until imemDone.
- FETCH, imemDone, squash=0, no stall, no redirect:
  - IF/ID <= {imemRdata, pc+PC_INC, imemErr}; pc <= pc+PC_INC.
  - Sustains 1 instruction/cycle when memory is single-cycle.
- FETCH, imemDone, stall=1: capture the response into the hold buffer; IF/ID unchanged; go to HOLD with imemReq low.
- HOLD, stall=0: IF/ID <= buffer; pc += PC_INC; return to FETCH.
- stall=1 without a new response: IF/ID holds its value exactly. Stall has no effect on pc.
- Redirect (priority over stall, done and haltIn-free states):
  - pc <= redirectPc; IF/ID <= bubble {NOP_INSTR, 0, 0}; hold buffer discarded; state <= FETCH.
  - If a request is outstanding with no imemDone this cycle, set squash=1.
- squash=1: the next imemDone is discarded (no IF/ID write), then squash clears. imemReq stays low until the squashed response returns, then re-issues at the new pc.
- Redirect and imemDone in the same cycle: the response is discarded, squash is not set, and the next cycle requests redirectPc.
- Instruction with opcode[15:11]==00000 (HALT), or imemErr=1, passed into IF/ID: enter DRAIN. No new requests.
  - DRAIN + redirect: go to FETCH (the halt was speculative).
- haltIn=1 in any state: go to HALTED. imemReq=0, IF/ID <= bubble, halted=1. HALTED exits only by reset; redirect is ignored there.
- Arithmetic: pc+PC_INC wraps modulo 2^16 (16'hFFFE -> 16'h0000). No error is raised on wrap.
- Reset asserted mid-request: state clears immediately. Any late imemDone after reset release is not expected; memory resets on the same rst.

Decomposition:
- Shared package: NOP_INSTR, the HALT opcode constant 5'b00000, the fetch FSM state encoding, PC_INC.
- One natural sub-module, fetch_hold_buf: a 17-bit (instr+err) single-entry skid buffer with load/clear, reused by later stages.
- PC and IF/ID registers use the team's dff cells with the inverted reset.

Test Plan:
1. Reset release, single-cycle memory returning 0x4000,0x4001,0x4002 -> imemAddr 0,2,4 on consecutive cycles; instrOut follows one cycle later with nextPcOut 2,4,6.
2. stall high 3 cycles while imemDone arrives with 0x5A5A -> IF/ID unchanged, imemReq low, buffer holds the data. On release, instrOut=0x5A5A, nextPcOut=pc+2, then fetch resumes.
3. Memory latency 3 cycles, redirect to 0x0100 on cycle 1 of the request -> the response on cycle 3 is discarded; next imemAddr=0x0100; instrOut=0x0800 during the flush.
4. redirect and stall together -> IF/ID becomes the bubble (0x0800, 0), pc=redirectPc.
5. Fetch 0x0000 (HALT) at pc 0x0010 -> DRAIN with no requests. A redirect to 0x0020 resumes fetch at 0x0020. A haltIn pulse later gives halted=1, imemReq=0 forever.
6. pc=0xFFFE, fetch -> nextPcOut=0x0000, next imemAddr=0x0000. An imemErr response gives errOut=1 alongside that instruction, then DRAIN.
